// File: rtl/comp_pkg.sv
// Shared constants and the one-hot compare result encoding, ordered {gt,eq,lt}.
package comp_pkg;
  localparam int WIDTH_DEF = 2;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    RES_NONE = 3'b000,
    RES_LT   = 3'b001,
    RES_EQ   = 3'b010,
    RES_GT   = 3'b100
  } cmp_res_t;
endpackage

// File: rtl/comp_core.sv
// Combinational magnitude compare of a and b, unsigned or two's complement.
module comp_core
  import comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output cmp_res_t         res
);
  logic [WIDTH-1:0] msb_flip;
  logic [WIDTH-1:0] ua;
  logic [WIDTH-1:0] ub;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  always_comb begin
    msb_flip = '0;
    msb_flip[WIDTH-1] = signed_mode;
    ua = a ^ msb_flip;
    ub = b ^ msb_flip;
    if (ua == ub)     res = RES_EQ;
    else if (ua > ub) res = RES_GT;
    else              res = RES_LT;
  end
endmodule

// File: rtl/comp_2bit_reg.sv
// Registered comparator: one-cycle result with valid, plus saturating per-outcome counters.
module comp_2bit_reg
  import comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);
  cmp_res_t                  res;
  cmp_res_t                  res_q;
  logic [2:0]                hit;
  logic [2:0][CNT_W-1:0]     cnt;

  comp_core #(.WIDTH(WIDTH)) u_core (
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .res         (res)
  );

  assign hit = res;

  // Result holds across idle cycles; only out_valid tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res_q     <= RES_NONE;
    end else begin
      out_valid <= in_valid;
      if (in_valid) res_q <= res;
    end
  end

  // cnt[2]=gt, cnt[1]=eq, cnt[0]=lt, matching the result bit order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < 3; i++)
        if (hit[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  assign {gt, eq, lt} = res_q;
  assign gt_cnt = cnt[2];
  assign eq_cnt = cnt[1];
  assign lt_cnt = cnt[0];
endmodule

// File: tb/tb_comp_2bit_reg.sv
// Randomized + directed bench: CNT_W=8 and CNT_W=2 instances share stimulus, checked against a model.
module tb_comp_2bit_reg;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       signed_mode = 1'b0;
  logic [1:0] a = '0;
  logic [1:0] b = '0;
  logic       clr_cnt = 1'b0;

  logic       o8_valid, o8_gt, o8_eq, o8_lt;
  logic [7:0] o8_gtc, o8_eqc, o8_ltc;
  logic       o2_valid, o2_gt, o2_eq, o2_lt;
  logic [1:0] o2_gtc, o2_eqc, o2_ltc;

  int total = 0;
  int bad = 0;

  // Model state: counters indexed 0=gt, 1=eq, 2=lt.
  logic       exp_valid;
  logic [2:0] exp_res;
  int         c8 [3];
  int         c2 [3];

  comp_2bit_reg #(.WIDTH(2), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .signed_mode(signed_mode),
    .a(a), .b(b), .clr_cnt(clr_cnt), .out_valid(o8_valid),
    .gt(o8_gt), .eq(o8_eq), .lt(o8_lt),
    .gt_cnt(o8_gtc), .eq_cnt(o8_eqc), .lt_cnt(o8_ltc)
  );

  comp_2bit_reg #(.WIDTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .signed_mode(signed_mode),
    .a(a), .b(b), .clr_cnt(clr_cnt), .out_valid(o2_valid),
    .gt(o2_gt), .eq(o2_eq), .lt(o2_lt),
    .gt_cnt(o2_gtc), .eq_cnt(o2_eqc), .lt_cnt(o2_ltc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_int(input logic [1:0] x, input logic sm);
    return (sm && x[1]) ? int'(x) - 4 : int'(x);
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_res   = 3'b000;
    for (int i = 0; i < 3; i++) begin c8[i] = 0; c2[i] = 0; end
  endtask

  task automatic model_edge();
    int sa, sb, k;
    if (rst) begin
      model_reset();
      return;
    end
    exp_valid = in_valid;
    k = -1;
    if (in_valid) begin
      sa = to_int(a, signed_mode);
      sb = to_int(b, signed_mode);
      k  = (sa > sb) ? 0 : (sa == sb) ? 1 : 2;
      exp_res = 3'b100 >> k;
    end
    if (clr_cnt) begin
      for (int i = 0; i < 3; i++) begin c8[i] = 0; c2[i] = 0; end
    end else if (k >= 0) begin
      if (c8[k] < 255) c8[k]++;
      if (c2[k] < 3)   c2[k]++;
    end
  endtask

  task automatic check_all();
    chk("out_valid", o8_valid, exp_valid);
    chk("res8", {o8_gt, o8_eq, o8_lt}, exp_res);
    chk("gt_cnt8", o8_gtc, c8[0]);
    chk("eq_cnt8", o8_eqc, c8[1]);
    chk("lt_cnt8", o8_ltc, c8[2]);
    chk("out_valid2", o2_valid, exp_valid);
    chk("res2", {o2_gt, o2_eq, o2_lt}, exp_res);
    chk("gt_cnt2", o2_gtc, c2[0]);
    chk("eq_cnt2", o2_eqc, c2[1]);
    chk("lt_cnt2", o2_ltc, c2[2]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic sm, input logic [1:0] aa,
                       input logic [1:0] bb, input logic clr);
    in_valid = v; signed_mode = sm; a = aa; b = bb; clr_cnt = clr;
    step();
  endtask

  initial begin
    model_reset();
    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1 check_all();
    step();
    step();
    rst = 1'b0;

    // Unsigned directed
    drive(1, 0, 2'd2, 2'd1, 0);
    chk("u_gt", o8_gt, 1'b1);
    drive(1, 0, 2'd3, 2'd3, 0);
    chk("u_eq", o8_eq, 1'b1);
    drive(1, 0, 2'd0, 2'd3, 0);
    chk("u_lt", o8_lt, 1'b1);
    chk("u_cnts", {o8_gtc, o8_eqc, o8_ltc}, 24'h010101);

    // Signed directed
    drive(1, 1, 2'b10, 2'b01, 0);
    chk("s_lt", {o8_gt, o8_eq, o8_lt}, 3'b001);
    drive(1, 0, 2'b10, 2'b01, 0);
    chk("s_off_gt", {o8_gt, o8_eq, o8_lt}, 3'b100);
    drive(1, 1, 2'b11, 2'b10, 0);
    chk("s_gt", {o8_gt, o8_eq, o8_lt}, 3'b100);

    // Valid gating: result holds, counters untouched
    drive(1, 0, 2'd1, 2'd2, 0);
    drive(0, 0, 2'd3, 2'd0, 0);
    chk("gate_valid", o8_valid, 1'b0);
    chk("gate_lt", o8_lt, 1'b1);

    // Saturation on the CNT_W=2 instance
    drive(0, 0, 2'd0, 2'd0, 1);
    for (int i = 0; i < 5; i++) drive(1, 0, 2'd2, 2'd2, 0);
    chk("sat_eq2", o2_eqc, 2'd3);
    chk("nosat_eq8", o8_eqc, 8'd5);
    drive(1, 0, 2'd3, 2'd0, 1);
    chk("clr_pri", {o2_gtc, o2_eqc, o2_ltc, o8_gtc, o8_eqc, o8_ltc}, 36'h0);
    chk("clr_res", {o8_valid, o8_gt, o8_eq, o8_lt}, 4'b1100);

    // Random with mid-stream reset
    void'($urandom(87464));
    for (int i = 0; i < 15; i++) begin
      if (i == 8) begin
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1 check_all();
        step();
        rst = 1'b0;
      end
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 9) == 0));
    end
    drive(0, 0, 2'd0, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/comp_2bit_reg.md
Name: comp_2bit_reg

Overview:
- Registered 2-bit magnitude comparator with valid qualification and per-outcome event counters.
- Compares operands a and b and raises exactly one of gt/eq/lt one clock after a qualified input.
- Used as a leaf compare stage in datapath control logic; the counters support statistics and debug.

Parameters:
- WIDTH, 2, operand width in bits; the block is specified and verified at 2, and the RTL is width-generic.
- CNT_W, 8, width of each outcome counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a and b for this cycle.
- signed_mode  input  1  0 = unsigned compare; 1 = two's-complement compare.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- clr_cnt  input  1  synchronous clear of all three counters.
- out_valid  output  1  gt/eq/lt hold the result of an accepted compare.
- gt  output  1  a > b.
- eq  output  1  a == b.
- lt  output  1  a < b.
- gt_cnt  output  CNT_W  number of accepted compares with gt result.
- eq_cnt  output  CNT_W  number of accepted compares with eq result.
- lt_cnt  output  CNT_W  number of accepted compares with lt result.

Behaviour:
- Reset (asynchronous, rst=1): out_valid=0, gt=0, eq=0, lt=0, and all counters=0, applied immediately. Outputs stay at these values while rst is held.
- Compare latency: exactly 1 cycle. If in_valid=1 at rising edge N, then after edge N:
  - out_valid=1;
  - {gt,eq,lt} reflect a/b/signed_mode sampled at edge N.
- in_valid=0 at an edge: out_valid goes to 0, and gt/eq/lt hold their last values (not cleared).
- Result encoding: when out_valid=1, exactly one of gt/eq/lt is 1 (one-hot). The value 000 appears only after reset and before the first accepted compare.
- Unsigned mode: plain magnitude compare, range 0..3.
- Signed mode: operands are two's complement, range -2..1. Example: 2'b10 (-2) < 2'b01 (1).
- eq is independent of signed_mode.
- signed_mode is sampled per transaction; there is no persistent mode state.
- Counters: on each accepted compare, the counter matching the result increments by 1.
  - Saturation: a counter at 2^CNT_W-1 stays there; no wrap.
- clr_cnt=1 at an edge: all counters become 0. clr_cnt has priority over an increment in the same cycle.
- clr_cnt does not affect gt/eq/lt/out_valid.
- Reset asserted mid-operation: any in-flight result is discarded. After release, the first edge with in_valid=1 produces the next result.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package, comp_pkg:
  - WIDTH_DEF=2 and CNT_W_DEF=8 constants;
  - cmp_res_t enum {RES_NONE=3'b000, RES_LT=3'b001, RES_EQ=3'b010, RES_GT=3'b100}, ordered as {gt,eq,lt}.
- One sub-module, comp_core: purely combinational. Inputs a, b, signed_mode; output cmp_res_t.
- comp_2bit_reg instantiates comp_core and adds the result registers, valid register and three saturating counters.

Test Plan:
- Reset check: assert rst asynchronously with no clock edge -> out_valid=0, gt/eq/lt=000, and all counters 0 immediately.
- Unsigned directed, one compare per cycle -> each result appears one cycle after its input, and counters end at gt_cnt=1, eq_cnt=1, lt_cnt=1:
  - a=2, b=1 -> gt=1, eq=0, lt=0;
  - a=3, b=3 -> eq=1;
  - a=0, b=3 -> lt=1.
- Signed directed:
  - signed_mode=1, a=2'b10, b=2'b01 -> lt=1;
  - signed_mode=0, same operands -> gt=1;
  - signed_mode=1, a=2'b11, b=2'b10 -> gt=1.
- Valid gating: in_valid=1 (a=1, b=2), then in_valid=0 with a=3, b=0 -> out_valid drops to 0, lt stays 1, and counters are unchanged.
- Counters with CNT_W=2:
  - 5 consecutive eq compares -> eq_cnt saturates at 3;
  - clr_cnt=1 together with in_valid=1 -> all counters 0.
- Random: 15 random {a,b} vectors with seed 87464, plus a mid-stream reset -> every output matches the reference model one-hot result, and after reset exactly the post-reset accepted compares are counted.
